// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   state_t : FSM encoding (IDLE -> CALC -> DONE -> IDLE)
//   cnt_w() : width of the quotient-bit counter, $clog2(WIDTH_N+1)
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter has to hold WIDTH_N itself, hence the +1.
  function automatic int cnt_w(input int width_n);
    return $clog2(width_n + 1);
  endfunction

endpackage

// File: rtl/divider_seq_sign_mag_conv.sv
// Splits a value into {sign, magnitude}.
//   val  : input operand
//   sign : operand MSB when SIGNED, else 0
//   mag  : |val| held as an unsigned WIDTH-bit number, so the most-negative
//          value maps to 2^(WIDTH-1) with no overflow
module sign_mag_conv #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] val,
  output logic             sign,
  output logic [WIDTH-1:0] mag
);

  assign sign = SIGNED ? val[WIDTH-1] : 1'b0;
  assign mag  = sign ? -val : val;

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid/in_ready     : operand handshake; in_ready is high only in IDLE
//   N, D                  : dividend (WIDTH_N) and divisor (WIDTH_D)
//   out_valid/out_ready   : result handshake; result held until accepted
//   Q, R, div_by_zero     : quotient, remainder, divide-by-zero flag
// SIGNED=1 treats operands as two's complement and truncates toward zero
// (remainder takes the dividend's sign).
module divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH_N = 32,
  parameter int WIDTH_D = 16,
  parameter bit SIGNED  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] N,
  input  logic [WIDTH_D-1:0] D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] Q,
  output logic [WIDTH_D-1:0] R,
  output logic               div_by_zero
);

  localparam int CNT_W = cnt_w(WIDTH_N);

  state_t             state;
  logic [WIDTH_N-1:0] dvd;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH_D:0]   rem;
  logic [WIDTH_D-1:0] dsr;
  logic [CNT_W-1:0]   cnt;
  logic               sn, sq;

  logic               n_sign, d_sign;
  logic [WIDTH_N-1:0] n_mag;
  logic [WIDTH_D-1:0] d_mag;

  sign_mag_conv #(.WIDTH(WIDTH_N), .SIGNED(SIGNED)) u_n_conv (
    .val(N), .sign(n_sign), .mag(n_mag)
  );
  sign_mag_conv #(.WIDTH(WIDTH_D), .SIGNED(SIGNED)) u_d_conv (
    .val(D), .sign(d_sign), .mag(d_mag)
  );

  // One restoring step. rem < |D| before the shift, so its MSB is always
  // zero there and only the low WIDTH_D bits need to shift up.
  logic [WIDTH_D:0]   rem_sh, rem_nx;
  logic               q_bit;
  logic [WIDTH_N-1:0] quot_nx;
  logic               unused_rem_msb;

  always_comb begin
    rem_sh  = {rem[WIDTH_D-1:0], dvd[WIDTH_N-1]};
    q_bit   = (rem_sh >= {1'b0, dsr});
    rem_nx  = q_bit ? (rem_sh - {1'b0, dsr}) : rem_sh;
    quot_nx = {dvd[WIDTH_N-2:0], q_bit};
  end

  assign unused_rem_msb = rem[WIDTH_D];
  assign in_ready       = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dvd         <= '0;
      rem         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      sn          <= 1'b0;
      sq          <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dvd <= n_mag;
            dsr <= d_mag;
            rem <= '0;
            sn  <= n_sign;
            sq  <= n_sign ^ d_sign;
            cnt <= CNT_W'(WIDTH_N);
            if (D == '0) begin
              // Result is loaded now; out_valid follows one edge later in DONE.
              Q           <= '1;
              R           <= N[WIDTH_D-1:0];
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dvd <= quot_nx;
          rem <= rem_nx;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            Q           <= sq ? -quot_nx : quot_nx;
            R           <= sn ? -rem_nx[WIDTH_D-1:0] : rem_nx[WIDTH_D-1:0];
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;       // 0: unsigned DUT, 1: signed DUT
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] N = '0;
  logic [15:0] D = '0;

  logic        iv_u, ir_u, ov_u, dbz_u;
  logic        iv_s, ir_s, ov_s, dbz_s;
  logic [31:0] q_u, q_s;
  logic [15:0] r_u, r_s;

  assign iv_u = in_valid & ~sel;
  assign iv_s = in_valid & sel;

  always #5 clk = ~clk;

  divider_seq #(.WIDTH_N(32), .WIDTH_D(16), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_u), .in_ready(ir_u), .N(N), .D(D),
    .out_valid(ov_u), .out_ready(out_ready), .Q(q_u), .R(r_u), .div_by_zero(dbz_u)
  );
  divider_seq #(.WIDTH_N(32), .WIDTH_D(16), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s), .N(N), .D(D),
    .out_valid(ov_s), .out_ready(out_ready), .Q(q_s), .R(r_s), .div_by_zero(dbz_s)
  );

  logic        cur_ir, cur_ov, cur_dbz;
  logic [31:0] cur_q;
  logic [15:0] cur_r;
  always_comb begin
    cur_ir  = sel ? ir_s  : ir_u;
    cur_ov  = sel ? ov_s  : ov_u;
    cur_dbz = sel ? dbz_s : dbz_u;
    cur_q   = sel ? q_s   : q_u;
    cur_r   = sel ? r_s   : r_u;
  end

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    bit          dbz;
  } exp_t;

  typedef struct {
    bit          sgn;
    logic [31:0] n;
    logic [15:0] d;
    logic [31:0] q;
    logic [15:0] r;
    bit          dbz;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input bit sgn, input logic [31:0] n, input logic [15:0] d);
    exp_t   m;
    longint nn, dd, qq, rr;
    if (d == 16'd0) begin
      m.q = '1; m.r = n[15:0]; m.dbz = 1'b1;
      return m;
    end
    if (sgn) begin
      nn = longint'(signed'(n));
      dd = longint'(signed'(d));
    end else begin
      nn = longint'({32'd0, n});
      dd = longint'({48'd0, d});
    end
    qq = nn / dd;
    rr = nn % dd;
    m.q = qq[31:0]; m.r = rr[15:0]; m.dbz = 1'b0;
    return m;
  endfunction

  // Drive one operation and wait (bounded) for the accept edge.
  task automatic start_op(input bit sgn, input logic [31:0] n, input logic [15:0] d, input exp_t e);
    int w = 0;
    @(negedge clk);
    sel = sgn; N = n; D = d; in_valid = 1'b1;
    sb.push_back(e);
    while (!cur_ir && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cur_ir) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, optionally hold
  // out_ready low for `hold` cycles, then optionally complete the handshake.
  task automatic wait_result(input int exp_lat, input int hold, input bit do_hs);
    exp_t e;
    int   lat = 0;
    while (!cur_ov && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!cur_ov) chk("in_ready_busy", {63'd0, cur_ir}, 64'd0);
    end
    if (!cur_ov) begin
      chk("out_valid_timeout", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("Q", {32'd0, cur_q}, {32'd0, e.q});
    chk("R", {48'd0, cur_r}, {48'd0, e.r});
    chk("div_by_zero", {63'd0, cur_dbz}, {63'd0, e.dbz});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, cur_ov}, 64'd1);
      chk("hold_Q", {32'd0, cur_q}, {32'd0, e.q});
      chk("hold_R", {48'd0, cur_r}, {48'd0, e.r});
      chk("hold_in_ready", {63'd0, cur_ir}, 64'd0);
    end
    if (do_hs) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("hs_out_valid", {63'd0, cur_ov}, 64'd0);
      chk("hs_in_ready", {63'd0, cur_ir}, 64'd1);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] rn;
    logic [15:0] rd;

    vecs[0] = '{1'b0, 32'd100,        16'd7,      32'd14,         16'd2,      1'b0, 32};
    vecs[1] = '{1'b1, 32'hFFFF_FF9C,  16'd7,      32'hFFFF_FFF2,  16'hFFFE,   1'b0, 32};
    vecs[2] = '{1'b1, 32'd100,        16'hFFF9,   32'hFFFF_FFF2,  16'd2,      1'b0, 32};
    vecs[3] = '{1'b1, 32'hFFFF_FF9C,  16'hFFF9,   32'd14,         16'hFFFE,   1'b0, 32};
    vecs[4] = '{1'b0, 32'h1234,       16'd0,      32'hFFFF_FFFF,  16'h1234,   1'b1, 1};
    vecs[5] = '{1'b1, 32'h8000_0000,  16'hFFFF,   32'h8000_0000,  16'd0,      1'b0, 32};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'd0,      1'b0, 32};
    vecs[7] = '{1'b0, 32'd5,          16'd10,     32'd0,          16'd5,      1'b0, 32};
    vecs[8] = '{1'b1, 32'h1234,       16'd0,      32'hFFFF_FFFF,  16'h1234,   1'b1, 1};

    // Reset state of both instances.
    #12;
    chk("rst_ir_u", {63'd0, ir_u}, 64'd1);
    chk("rst_ov_u", {63'd0, ov_u}, 64'd0);
    chk("rst_q_u", {32'd0, q_u}, 64'd0);
    chk("rst_r_s", {48'd0, r_s}, 64'd0);
    chk("rst_dbz_s", {63'd0, dbz_s}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      e.q = vecs[i].q; e.r = vecs[i].r; e.dbz = vecs[i].dbz;
      start_op(vecs[i].sgn, vecs[i].n, vecs[i].d, e);
      wait_result(vecs[i].lat, 0, 1'b1);
    end

    // Back-pressure: hold 10 cycles, then raise out_ready with in_valid already high.
    e.q = 32'd333; e.r = 16'd1; e.dbz = 1'b0;
    start_op(1'b0, 32'd1000, 16'd3, e);
    wait_result(32, 10, 1'b0);
    out_ready = 1'b1;
    N = 32'd50; D = 16'd6; in_valid = 1'b1;
    e.q = 32'd8; e.r = 16'd2; e.dbz = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_out_valid", {63'd0, cur_ov}, 64'd0);
    chk("bp_in_ready", {63'd0, cur_ir}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(32, 0, 1'b1);

    // Reset in the middle of CALC, then a fresh operation.
    e.q = 32'd333; e.r = 16'd1; e.dbz = 1'b0;
    start_op(1'b0, 32'd1000, 16'd3, e);
    repeat (5) @(negedge clk);
    chk("mid_ir_busy", {63'd0, ir_u}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", {63'd0, ir_u}, 64'd1);
    chk("mid_rst_ov", {63'd0, ov_u}, 64'd0);
    chk("mid_rst_q", {32'd0, q_u}, 64'd0);
    chk("mid_rst_r", {48'd0, r_u}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    e.q = 32'd142857; e.r = 16'd1; e.dbz = 1'b0;
    start_op(1'b0, 32'd999_999 + 32'd1, 16'd7, e);
    wait_result(32, 0, 1'b1);

    // Random scoreboard against a behavioural / and %.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 500; k++) begin
        rn = $urandom;
        case ($urandom_range(0, 15))
          0:       rd = 16'd0;
          1, 2:    rd = 16'($urandom_range(1, 15));
          3:       begin rn = 32'h8000_0000; rd = 16'hFFFF; end
          default: rd = 16'($urandom);
        endcase
        start_op(s[0], rn, rd, model(s[0], rn, rd));
        wait_result((rd == 16'd0) ? 1 : 32, $urandom_range(0, 2), 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
